// File: rtl/bus_master_port.sv
// Master side of the serial request bus. Takes one parallel read or write
// request, handshakes it to the slave, shifts the address and write data
// out MSB first, shifts read data back in and returns a parallel response.
// A no-progress watchdog and a premature slave_tx_done abort with resp_err.
module bus_master_port #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              read_en,
    output logic              write_en,
    output logic              master_valid,
    output logic              master_ready,
    input  logic              slave_ready,
    input  logic              slave_valid,
    output logic              tx_address,
    output logic              tx_data,
    output logic              tx_burst,
    input  logic              rx_data,
    input  logic              slave_tx_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int K_W   = $clog2(ADDR_W);
    localparam int S_W   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_WAIT,
        S_RDATA,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [S_W-1:0]    nsamp_q, nsamp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic              timed_out;
    logic              last_sample;

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timed_out   = (cnt_inc == CNT_W'(TIMEOUT));
    assign last_sample = (nsamp_q == S_W'(DATA_W - 1));

    // Next-state, watchdog and datapath updates for the transaction FSM.
    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        nsamp_d = nsamp_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (slave_ready) begin
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ADDR: begin
                // Shift left with zero fill: tx_data runs out to 0 after DATA_W bits.
                addr_d  = addr_q << 1;
                wdata_d = wdata_q << 1;
                k_d     = k_q + K_W'(1);
                if (k_q == K_W'(ADDR_W - 1)) begin
                    cnt_d   = '0;
                    nsamp_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT, S_RDATA: begin
                if (write_q) begin
                    if (slave_valid) begin
                        err_d   = 1'b0;
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else if (timed_out) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (slave_valid && last_sample) begin
                    // A done strobe alongside the final bit is a clean finish.
                    err_d   = 1'b0;
                    rdata_d = {rx_q[DATA_W-2:0], rx_data};
                    state_d = S_DONE;
                end else if (slave_tx_done) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (slave_valid) begin
                    rx_d    = {rx_q[DATA_W-2:0], rx_data};
                    nsamp_d = nsamp_q + S_W'(1);
                    cnt_d   = '0;
                    state_d = S_RDATA;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            rx_q    <= '0;
            nsamp_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            nsamp_q <= nsamp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from registers only, so they are glitch-free and drop at once on reset.
    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = (state_q == S_DONE);
    assign resp_rdata   = (state_q == S_DONE) ? rdata_q : '0;
    assign resp_err     = (state_q == S_DONE) & err_q;
    assign master_valid = (state_q == S_REQ) | (state_q == S_ADDR);
    assign write_en     = write_q & ((state_q == S_REQ) | (state_q == S_ADDR) | (state_q == S_WAIT));
    assign read_en      = ~write_q & ((state_q == S_REQ) | (state_q == S_ADDR) |
                                      (state_q == S_WAIT) | (state_q == S_RDATA));
    assign master_ready = ~write_q & ((state_q == S_WAIT) | (state_q == S_RDATA));
    assign tx_address   = (state_q == S_ADDR) & addr_q[ADDR_W-1];
    assign tx_data      = (state_q == S_ADDR) & write_q & wdata_q[DATA_W-1];
    assign tx_burst     = 1'b0;

endmodule

// File: tb/tb_bus_master_port.sv
// Randomised scoreboard bench for bus_master_port. A driver plays requester
// and slave from a per-transaction plan; an arithmetic model of the plan
// predicts error, read data and response cycle; a monitor pops and compares.
module tb_bus_master_port;

    localparam int T = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [7:0]  resp_rdata;
    logic        read_en, write_en, master_valid, master_ready;
    logic        slave_ready, slave_valid;
    logic        tx_address, tx_data, tx_burst;
    logic        rx_data, slave_tx_done;

    bus_master_port dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .read_en      (read_en),
        .write_en     (write_en),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .slave_ready  (slave_ready),
        .slave_valid  (slave_valid),
        .tx_address   (tx_address),
        .tx_data      (tx_data),
        .tx_burst     (tx_burst),
        .rx_data      (rx_data),
        .slave_tx_done(slave_tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    // Transaction plan
    logic        p_write;
    logic [11:0] p_addr;
    logic [7:0]  p_wdata;
    logic [7:0]  p_rbyte;
    int          p_dreq, p_wgap, p_done_idx, p_hold;
    int          p_gap[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: response outcome and cycle offset from acceptance, from the plan alone.
    function automatic void model(output logic err, output logic [7:0] rd, output int lat);
        int cur;
        err = 1'b0;
        rd  = 8'h00;
        if (p_dreq >= T) begin
            err = 1'b1;
            lat = 1 + T;
            return;
        end
        cur = 14 + p_dreq;
        if (p_write) begin
            if (p_wgap >= T) begin
                err = 1'b1;
                lat = cur + T;
            end else begin
                lat = cur + p_wgap + 1;
            end
            return;
        end
        for (int s = 0; s < 8; s++) begin
            if (p_done_idx == s) begin
                err = 1'b1;
                lat = cur + 1;
                return;
            end
            if (p_gap[s] >= T) begin
                err = 1'b1;
                lat = cur + T;
                return;
            end
            cur += p_gap[s] + 1;
        end
        rd  = p_rbyte;
        lat = cur;
    endfunction

    // Monitor: pops on each new response and watches it stay stable while held.
    logic prev_rv = 1'b0;
    exp_t cur_exp;
    always @(negedge clk) begin
        if (resp_valid && !prev_rv) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                cur_exp = exp_q.pop_front();
                check("resp_err", 32'(resp_err), 32'(cur_exp.err));
                check("resp_rdata", 32'(resp_rdata), 32'(cur_exp.rdata));
                check("resp_cycle", 32'(cyc), 32'(cur_exp.at));
            end
        end else if (resp_valid && prev_rv) begin
            check("held_rdata", 32'(resp_rdata), 32'(cur_exp.rdata));
            check("held_err", 32'(resp_err), 32'(cur_exp.err));
        end
        prev_rv = resp_valid;
    end

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic accept(output bit ok);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (!ok) begin
            check("req_ready_wait", 32'd0, 32'd1);
            pulse_reset();
        end
        req_valid = 1'b1;
        req_write = p_write;
        req_addr  = p_addr;
        req_wdata = p_wdata;
    endtask

    task automatic run_txn();
        exp_t e;
        bit   ok;
        bit   aborted = 1'b0;
        int   lat;
        int   n;
        accept(ok);
        model(e.err, e.rdata, lat);
        e.at = cyc + lat;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 12'($urandom);
        for (int i = 0; i <= p_dreq && i < T; i++) begin
            check("req_master_valid", 32'(master_valid), 32'd1);
            check("req_rw_en", 32'({read_en, write_en}), 32'({~p_write, p_write}));
            slave_ready = (i == p_dreq);
            @(negedge clk);
        end
        slave_ready = 1'b0;
        if (p_dreq >= T) aborted = 1'b1;
        if (!aborted) begin
            for (int k = 0; k < 12; k++) begin
                check("tx_address", 32'(tx_address), 32'(p_addr[11-k]));
                check("tx_data", 32'(tx_data), (p_write && k < 8) ? 32'(p_wdata[7-k]) : 32'd0);
                check("addr_master_valid", 32'(master_valid), 32'd1);
                @(negedge clk);
            end
            if (p_write) begin
                for (int j = 0; j <= p_wgap && j < T; j++) begin
                    check("wait_w_sig", 32'({write_en, master_valid, master_ready}), 32'b100);
                    slave_valid = (j == p_wgap);
                    @(negedge clk);
                end
                slave_valid = 1'b0;
            end else begin
                for (int s = 0; s < 8 && !aborted; s++) begin
                    if (p_done_idx == s) begin
                        slave_tx_done = 1'b1;
                        check("rd_master_ready", 32'(master_ready), 32'd1);
                        @(negedge clk);
                        slave_tx_done = 1'b0;
                        aborted = 1'b1;
                    end else begin
                        for (int j = 0; j <= p_gap[s] && j < T; j++) begin
                            check("rd_sig", 32'({master_ready, read_en, master_valid}), 32'b110);
                            slave_valid   = (j == p_gap[s]);
                            rx_data       = (j == p_gap[s]) ? p_rbyte[7-s] : 1'($urandom);
                            slave_tx_done = (j == p_gap[s]) && (s == 7) && (p_done_idx == 8);
                            @(negedge clk);
                        end
                        slave_valid   = 1'b0;
                        slave_tx_done = 1'b0;
                        if (p_gap[s] >= T) aborted = 1'b1;
                    end
                end
            end
        end
        n = 0;
        while (!resp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            check("resp_valid_wait", 32'd0, 32'd1);
            pulse_reset();
            return;
        end
        for (int h = 0; h < p_hold; h++) begin
            check("done_sig", 32'({req_ready, read_en, write_en, master_ready, master_valid}), 32'd0);
            req_valid = 1'b1;
            req_write = 1'($urandom);
            req_addr  = 12'($urandom);
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("req_ready_after_take", 32'({req_ready, resp_valid}), 32'b10);
    endtask

    task automatic plan_clear();
        p_dreq = 0; p_wgap = 0; p_done_idx = 9; p_hold = 0;
        for (int s = 0; s < 8; s++) p_gap[s] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        resp_ready = 0; slave_ready = 0; slave_valid = 0; rx_data = 0; slave_tx_done = 0;
        #1;
        check("reset_outputs", 32'({resp_valid, resp_rdata, resp_err, read_en, write_en, master_valid,
                                     master_ready, tx_address, tx_data, tx_burst}), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed write, zero-wait slave
        plan_clear();
        p_write = 1; p_addr = 12'hA5C; p_wdata = 8'h3B;
        run_txn();

        // Read with two stall gaps, response held for 10 cycles
        plan_clear();
        p_write = 0; p_addr = 12'h001; p_rbyte = 8'hC6; p_gap[3] = 1; p_gap[6] = 1; p_hold = 10;
        run_txn();

        // slave_ready never comes, then a normal request
        plan_clear();
        p_write = 0; p_addr = 12'h7F0; p_dreq = T;
        run_txn();
        plan_clear();
        p_write = 1; p_addr = 12'h123; p_wdata = 8'h99;
        run_txn();

        // Premature done after 5 samples, then done with the 8th sample
        plan_clear();
        p_write = 0; p_addr = 12'h3C3; p_rbyte = 8'h5A; p_done_idx = 5;
        run_txn();
        plan_clear();
        p_write = 0; p_addr = 12'h3C4; p_rbyte = 8'hA7; p_done_idx = 8;
        run_txn();

        // Watchdog boundaries: one short of the limit survives, the limit aborts
        plan_clear();
        p_write = 1; p_addr = 12'hFFF; p_wdata = 8'hFF; p_dreq = T - 1;
        run_txn();
        plan_clear();
        p_write = 1; p_addr = 12'h800; p_wdata = 8'h80; p_wgap = T - 1;
        run_txn();
        plan_clear();
        p_write = 1; p_addr = 12'h800; p_wdata = 8'h01; p_wgap = T;
        run_txn();
        plan_clear();
        p_write = 0; p_addr = 12'h055; p_rbyte = 8'h81; p_gap[4] = T - 1;
        run_txn();
        plan_clear();
        p_write = 0; p_addr = 12'h056; p_rbyte = 8'h18; p_gap[2] = T;
        run_txn();

        // Reset in the middle of the address phase
        plan_clear();
        p_write = 1; p_addr = 12'hABC; p_wdata = 8'h42;
        begin
            bit ok;
            accept(ok);
            @(negedge clk);
            req_valid   = 1'b0;
            slave_ready = 1'b1;
            @(negedge clk);
            slave_ready = 1'b0;
            for (int k = 0; k < 6; k++) @(negedge clk);
            #2 reset = 1'b1;
            #1;
            check("midreset_outputs", 32'({resp_valid, resp_rdata, resp_err, read_en, write_en, master_valid,
                                            master_ready, tx_address, tx_data, tx_burst}), 32'd0);
            check("midreset_req_ready", 32'(req_ready), 32'd1);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
        end
        plan_clear();
        p_write = 1; p_addr = 12'h5A5; p_wdata = 8'hC3;
        run_txn();

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            plan_clear();
            p_write = 1'($urandom);
            p_addr  = 12'($urandom);
            p_wdata = 8'($urandom);
            p_rbyte = 8'($urandom);
            p_dreq  = $urandom_range(0, 4);
            p_wgap  = $urandom_range(0, 4);
            p_hold  = $urandom_range(0, 3);
            for (int s = 0; s < 8; s++) p_gap[s] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            p_done_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : 9;
            run_txn();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
Master-side serial bus interface that sits directly upstream of the slave block and drives its serial request lines.
- Accepts one parallel read or write request at a time from a local requester.
- Performs the master_valid/slave_ready handshake, then shifts a 12-bit address and 8-bit write data out MSB first.
- Shifts 8 bits of read data back in and returns a parallel response with an error flag for timeout or protocol violation.

Parameters:
ADDR_W, 12, address width; equals the slave memory address width.
DATA_W, 8, data width.
TIMEOUT, 256, consecutive no-progress cycles before a transaction aborts with an error.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  high exactly when state is IDLE.
req_write  input  1  1 = write, 0 = read.
req_addr  input  ADDR_W  request address.
req_wdata  input  DATA_W  write data.
resp_valid  output  1  response present; held until taken.
resp_ready  input  1  requester accepts the response.
resp_rdata  output  DATA_W  read data; 0 for writes and errors.
resp_err  output  1  transaction aborted.
read_en  output  1  to slave; high from REQ through RDATA for reads.
write_en  output  1  to slave; high from REQ through WAIT for writes.
master_valid  output  1  high in REQ and ADDR.
master_ready  output  1  high in WAIT and RDATA for reads.
slave_ready  input  1  slave accepts the request.
slave_valid  input  1  read data bit valid, or write acknowledge.
tx_address  output  1  serial address, MSB first.
tx_data  output  1  serial write data, MSB first.
tx_burst  output  1  single-beat only; constant 0.
rx_data  input  1  serial read data from the slave, MSB first.
slave_tx_done  input  1  slave finished sending read data.

Behaviour:
Reset:
- Asynchronous; takes effect immediately, including mid-transaction.
- State returns to IDLE; counters and shift registers clear.
- All outputs 0 except req_ready = 1.
- A transaction in progress is dropped; no response is issued.

States and transitions:
- IDLE: on req_valid & req_ready, latch write, addr and wdata, then go to REQ.
- REQ: master_valid = 1 and read_en/write_en are set. When slave_ready is sampled high, go to ADDR with bit count k = 0.
- ADDR: 12 cycles, k = 0..11. tx_address = addr[11-k]. tx_data = wdata[7-k] for a write with k < 8, otherwise 0. After k = 11, go to WAIT; master_valid drops with the transition.
- WAIT, write:
  - First cycle with slave_valid high is the acknowledge.
  - Go to DONE with resp_err = 0 and resp_rdata = 0.
- WAIT/RDATA, read:
  - Sample rx_data on every cycle where master_ready & slave_valid; the first sample is bit 7.
  - The first sample moves WAIT to RDATA.
  - Cycles with slave_valid low stall; no sample is taken.
  - After the 8th sample, go to DONE with the assembled byte and resp_err = 0.
- DONE:
  - resp_valid = 1; resp_rdata and resp_err are stable.
  - read_en, write_en and master_ready are 0.
  - On resp_ready, go to IDLE; req_ready rises the next cycle.

Timeout:
- Counter resets on entry to REQ, on the first WAIT cycle, and on every sample or acknowledge.
- It increments every other REQ, WAIT or RDATA cycle.
- When the counter reaches TIMEOUT, go to DONE with resp_err = 1 and resp_rdata = 0.

Protocol error:
- slave_tx_done high during a read before the 8th sample is taken -> DONE with resp_err = 1.
- slave_tx_done is ignored in all other states.
- slave_valid is ignored outside WAIT and RDATA.

Simultaneous events:
- slave_tx_done together with the 8th sample is normal completion with no error.
- A timeout and a sample in the same cycle: the sample wins and the counter resets.
- req_valid is ignored while not in IDLE.

Latency with a zero-wait slave:
- Accept at cycle 0, REQ at cycle 1, ADDR cycles 2-13, WAIT at cycle 14.
- Write: acknowledge at cycle 14, resp_valid at cycle 15.
- Read: samples at cycles 14-21, resp_valid at cycle 22.

Test Plan:
- Write addr 0xA5C, data 0x3B; slave_ready and an ack at the first opportunity -> tx_address sequence 1010_0101_1100, tx_data 0011_1011 then 0000, resp_valid at cycle 15, resp_err 0.
- Read addr 0x001; slave returns 0xC6 with two slave_valid-low gaps mid-byte -> resp_rdata 0xC6, resp_valid at cycle 24, master_ready high throughout WAIT and RDATA.
- slave_ready held low for TIMEOUT = 256 cycles -> resp_err 1, resp_rdata 0, master_valid drops, and the next request is accepted normally.
- Read where slave_tx_done pulses after 5 samples -> resp_err 1. Repeat with slave_tx_done on the 8th sample -> resp_err 0.
- Hold resp_ready low for 10 cycles -> resp_valid and resp_rdata stable for 10 cycles, req_ready 0, and a new req_valid is ignored.
- Assert reset during ADDR at k = 6 -> all outputs 0 and req_ready 1 immediately, with no response; a following write completes correctly.
